// File: rtl/day2_puzzle.sv
// day2_puzzle: parallel range scanners that sum every ID whose decimal form is a repeated digit block.
// Optional feature macro DAY2_INVALID_COUNT_EN adds the invalid_count output (number of invalid IDs).
module day2_puzzle #(
    parameter int W         = 48,
    parameter int NUM_UNITS = 38,
    parameter int PUZZLE    = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] start_id [0:NUM_UNITS-1],
    input  logic [W-1:0] end_id   [0:NUM_UNITS-1],
    output logic [W-1:0] id_sum,
`ifdef DAY2_INVALID_COUNT_EN
    output logic [W-1:0] invalid_count,
`endif
    output logic         done
);

    // Decimal digits needed for any W-bit value: floor(W*log10(2)) + 1.
    localparam int ND = (W * 30103) / 100000 + 1;
    localparam int NS = (NUM_UNITS + 1) / 2;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_SCAN, S_DONE} unit_state_t;

    function automatic logic [4*ND-1:0] dd_step(input logic [4*ND-1:0] bcd, input logic bit_in);
        logic [4*ND-1:0] adj;
        adj = bcd;
        for (int d = 0; d < ND; d++)
            if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        return {adj[4*ND-2:0], bit_in};
    endfunction

    function automatic logic [4*ND-1:0] bcd_inc(input logic [4*ND-1:0] bcd);
        logic [4*ND-1:0] nxt;
        logic            carry;
        nxt   = bcd;
        carry = 1'b1;
        for (int d = 0; d < ND; d++) begin
            if (carry) begin
                if (nxt[4*d +: 4] == 4'd9) begin
                    nxt[4*d +: 4] = 4'd0;
                end else begin
                    nxt[4*d +: 4] = nxt[4*d +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return nxt;
    endfunction

    // Length comes from the highest non-zero digit; digits above it are never compared.
    function automatic logic is_invalid(input logic [4*ND-1:0] bcd);
        int   len;
        logic inv;
        logic ok;
        len = 1;
        for (int d = 0; d < ND; d++)
            if (bcd[4*d +: 4] != 4'd0) len = d + 1;
        inv = 1'b0;
        for (int k = 1; k < ND; k++) begin
            if (k < len && (len % k) == 0 && (PUZZLE != 1 || 2 * k == len)) begin
                ok = 1'b1;
                for (int j = 0; j + k < ND; j++)
                    if (j < len - k && bcd[4*j +: 4] != bcd[4*(j+k) +: 4]) ok = 1'b0;
                inv = inv | ok;
            end
        end
        return inv;
    endfunction

    logic [W-1:0]         w_acc [0:2*NS-1];
`ifdef DAY2_INVALID_COUNT_EN
    logic [W-1:0]         w_cnt [0:2*NS-1];
`endif
    logic [NUM_UNITS-1:0] w_unit_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            unit_state_t     r_state;
            logic [W-1:0]    r_bin;
            logic [W-1:0]    r_end;
            logic [W-1:0]    r_sh;
            logic [W-1:0]    r_acc;
            logic [4*ND-1:0] r_bcd;
            logic [CW-1:0]   r_dd_cnt;
            logic            w_inv;
`ifdef DAY2_INVALID_COUNT_EN
            logic [W-1:0]    r_icnt;
`endif

            assign w_inv = is_invalid(r_bcd);

            // NOTE: reset is synchronous and clears every register, so no stale range survives it.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_state  <= S_IDLE;
                    r_bin    <= '0;
                    r_end    <= '0;
                    r_sh     <= '0;
                    r_acc    <= '0;
                    r_bcd    <= '0;
                    r_dd_cnt <= '0;
`ifdef DAY2_INVALID_COUNT_EN
                    r_icnt   <= '0;
`endif
                end else if (load) begin
                    r_state  <= S_CONV;
                    r_bin    <= start_id[gi];
                    r_end    <= end_id[gi];
                    r_sh     <= start_id[gi];
                    r_acc    <= '0;
                    r_bcd    <= '0;
                    r_dd_cnt <= '0;
`ifdef DAY2_INVALID_COUNT_EN
                    r_icnt   <= '0;
`endif
                end else if (en) begin
                    case (r_state)
                        S_CONV: begin
                            if (r_dd_cnt == '0 && r_bin > r_end) begin
                                r_state <= S_DONE;
                            end else begin
                                r_bcd    <= dd_step(r_bcd, r_sh[W-1]);
                                r_sh     <= r_sh << 1;
                                r_dd_cnt <= r_dd_cnt + 1'b1;
                                if (r_dd_cnt == CW'(W - 1)) r_state <= S_SCAN;
                            end
                        end
                        S_SCAN: begin
                            if (w_inv) begin
                                r_acc <= r_acc + r_bin;
`ifdef DAY2_INVALID_COUNT_EN
                                r_icnt <= r_icnt + 1'b1;
`endif
                            end
                            if (r_bin == r_end) begin
                                r_state <= S_DONE;
                            end else begin
                                r_bin <= r_bin + 1'b1;
                                r_bcd <= bcd_inc(r_bcd);
                            end
                        end
                        default: r_state <= r_state;
                    endcase
                end
            end

            assign w_acc[gi]       = r_acc;
            assign w_unit_done[gi] = (r_state == S_DONE);
`ifdef DAY2_INVALID_COUNT_EN
            assign w_cnt[gi]       = r_icnt;
`endif
        end

        for (gi = NUM_UNITS; gi < 2 * NS; gi++) begin : g_pad
            assign w_acc[gi] = '0;
`ifdef DAY2_INVALID_COUNT_EN
            assign w_cnt[gi] = '0;
`endif
        end
    endgenerate

    // Chain stage s adds the pair (2s, 2s+1) onto the previous stage's running total.
    logic [W-1:0] r_stage [0:NS-1];
    logic         r_done;

    always_ff @(posedge clock) begin
        if (!reset || load) begin
            for (int s = 0; s < NS; s++) r_stage[s] <= '0;
            r_done <= 1'b0;
        end else begin
            r_stage[0] <= w_acc[0] + w_acc[1];
            for (int s = 1; s < NS; s++)
                r_stage[s] <= r_stage[s-1] + w_acc[2*s] + w_acc[2*s+1];
            r_done <= &w_unit_done;
        end
    end

    assign id_sum = r_stage[NS-1];
    assign done   = r_done;

`ifdef DAY2_INVALID_COUNT_EN
    logic [W-1:0] r_cstage [0:NS-1];

    always_ff @(posedge clock) begin
        if (!reset || load) begin
            for (int s = 0; s < NS; s++) r_cstage[s] <= '0;
        end else begin
            r_cstage[0] <= w_cnt[0] + w_cnt[1];
            for (int s = 1; s < NS; s++)
                r_cstage[s] <= r_cstage[s-1] + w_cnt[2*s] + w_cnt[2*s+1];
        end
    end

    assign invalid_count = r_cstage[NS-1];
`endif

endmodule

// File: tb/tb_day2_puzzle.sv
// Bench for day2_puzzle: four instances (1 and 11 units, both puzzle rules) against a string-based model.
module tb_day2_puzzle;

    localparam int W   = 48;
    localparam int N11 = 11;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, load, en;
    logic [W-1:0] s1  [0:0];
    logic [W-1:0] e1  [0:0];
    logic [W-1:0] s11 [0:N11-1];
    logic [W-1:0] e11 [0:N11-1];
    logic [W-1:0] sum_1p1, sum_1p2, sum_11p1, sum_11p2;
    logic         done_1p1, done_1p2, done_11p1, done_11p2;
`ifdef DAY2_INVALID_COUNT_EN
    logic [W-1:0] cnt_1p1, cnt_1p2, cnt_11p1, cnt_11p2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    day2_puzzle #(.W(W), .NUM_UNITS(1), .PUZZLE(1)) u_1p1 (
        .clock(clock), .reset(reset), .load(load), .en(en),
        .start_id(s1), .end_id(e1), .id_sum(sum_1p1),
`ifdef DAY2_INVALID_COUNT_EN
        .invalid_count(cnt_1p1),
`endif
        .done(done_1p1));

    day2_puzzle #(.W(W), .NUM_UNITS(1), .PUZZLE(2)) u_1p2 (
        .clock(clock), .reset(reset), .load(load), .en(en),
        .start_id(s1), .end_id(e1), .id_sum(sum_1p2),
`ifdef DAY2_INVALID_COUNT_EN
        .invalid_count(cnt_1p2),
`endif
        .done(done_1p2));

    day2_puzzle #(.W(W), .NUM_UNITS(N11), .PUZZLE(1)) u_11p1 (
        .clock(clock), .reset(reset), .load(load), .en(en),
        .start_id(s11), .end_id(e11), .id_sum(sum_11p1),
`ifdef DAY2_INVALID_COUNT_EN
        .invalid_count(cnt_11p1),
`endif
        .done(done_11p1));

    day2_puzzle #(.W(W), .NUM_UNITS(N11), .PUZZLE(2)) u_11p2 (
        .clock(clock), .reset(reset), .load(load), .en(en),
        .start_id(s11), .end_id(e11), .id_sum(sum_11p2),
`ifdef DAY2_INVALID_COUNT_EN
        .invalid_count(cnt_11p2),
`endif
        .done(done_11p2));

    // Reference rule: the decimal string equals some prefix block repeated L/k times.
    function automatic bit model_invalid(input longint v, input int p);
        string s;
        string rep;
        int    len;
        s   = $sformatf("%0d", v);
        len = s.len();
        for (int k = 1; k < len; k++) begin
            if ((len % k) == 0 && (p == 2 || 2 * k == len)) begin
                rep = "";
                for (int r = 0; r < len / k; r++) rep = {rep, s.substr(0, k - 1)};
                if (rep == s) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic longint model_sum(input longint a, input longint b, input int p);
        longint acc;
        acc = 0;
        for (longint v = a; v <= b; v++) if (model_invalid(v, p)) acc += v;
        return acc;
    endfunction

    function automatic longint model_cnt(input longint a, input longint b, input int p);
        longint c;
        c = 0;
        for (longint v = a; v <= b; v++) if (model_invalid(v, p)) c++;
        return c;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_done(input string tag);
        check({tag, " done_1p1"},  W'(done_1p1),  W'(1));
        check({tag, " done_1p2"},  W'(done_1p2),  W'(1));
        check({tag, " done_11p1"}, W'(done_11p1), W'(1));
        check({tag, " done_11p2"}, W'(done_11p2), W'(1));
    endtask

    // Single-unit instances get (a,b); the 11-unit instances get (a,b) in unit 0 and empty ranges elsewhere.
    task automatic set_one(input longint a, input longint b);
        s1[0] = W'(a);
        e1[0] = W'(b);
        for (int i = 0; i < N11; i++) begin
            s11[i] = (i == 0) ? W'(a) : W'(50);
            e11[i] = (i == 0) ? W'(b) : W'(40);
        end
    endtask

    task automatic pulse_load();
        @(negedge clock);
        load = 1'b1;
        en   = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    // Bounded wait for every instance to finish, then enough cycles for the longest adder chain.
    task automatic run_all(input bit jitter);
        int c;
        pulse_load();
        c = 0;
        while (!(done_1p1 && done_1p2 && done_11p1 && done_11p2) && c < 5000) begin
            if (jitter) en = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            c++;
        end
        en = 1'b1;
        repeat ((N11 + 1) / 2 + 1) @(negedge clock);
    endtask

    task automatic check_one(input string tag, input longint p1, input longint p2);
        check_done(tag);
        check({tag, " sum_1p1"},  sum_1p1,  W'(p1));
        check({tag, " sum_1p2"},  sum_1p2,  W'(p2));
        check({tag, " sum_11p1"}, sum_11p1, W'(p1));
        check({tag, " sum_11p2"}, sum_11p2, W'(p2));
    endtask

    initial begin
        longint ra [0:N11-1];
        longint rb [0:N11-1];
        longint exp1, exp2, blk, v, scale, off;
        longint ec1, ec2;

        reset = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        set_one(0, 0);
        repeat (3) @(negedge clock);
        check("reset sum_1p1",  sum_1p1,  '0);
        check("reset sum_11p2", sum_11p2, '0);
        check("reset done_1p2", W'(done_1p2),  '0);
        check("reset done_11p1", W'(done_11p1), '0);
        reset = 1'b1;

        // Reset override: load high while reset low must not start anything.
        set_one(11, 22);
        @(negedge clock);
        reset = 1'b0;
        load  = 1'b1;
        en    = 1'b1;
        repeat (80) @(negedge clock);
        check("reset beats load done", W'(done_1p1), '0);
        check("reset beats load sum",  sum_1p1,      '0);
        reset = 1'b1;
        load  = 1'b0;

        set_one(11, 22);
        run_all(1'b0);
        check_one("r11_22", 33, 33);

        set_one(95, 115);
        run_all(1'b0);
        check_one("r95_115", 99, 210);

        set_one(998, 1012);
        run_all(1'b0);
        check_one("r998_1012", 1010, 2009);

        set_one(50, 40);
        run_all(1'b0);
        check_one("r50_40", 0, 0);

        s1[0]   = W'(11);           e1[0]   = W'(22);
        s11[0]  = W'(11);           e11[0]  = W'(22);
        s11[1]  = W'(95);           e11[1]  = W'(115);
        s11[2]  = W'(998);          e11[2]  = W'(1012);
        s11[3]  = W'(1188511880);   e11[3]  = W'(1188511890);
        s11[4]  = W'(222220);       e11[4]  = W'(222224);
        s11[5]  = W'(1698522);      e11[5]  = W'(1698528);
        s11[6]  = W'(446443);       e11[6]  = W'(446449);
        s11[7]  = W'(38593856);     e11[7]  = W'(38593862);
        s11[8]  = W'(565653);       e11[8]  = W'(565659);
        s11[9]  = W'(824824821);    e11[9]  = W'(824824827);
        s11[10] = W'(2121212118);   e11[10] = W'(2121212124);
        run_all(1'b0);
        check_done("example");
        check("example p1", sum_11p1, 48'd1227775554);
        check("example p2", sum_11p2, 48'd4174379265);
        repeat (20) @(negedge clock);
        check("example hold done", W'(done_11p2), W'(1));
        check("example hold sum",  sum_11p2, 48'd4174379265);

        // Reset in the middle of a long scan.
        set_one(1000, 100000);
        pulse_load();
        repeat (100) @(negedge clock);
        check("midscan busy", W'(done_1p1), '0);
        reset = 1'b0;
        @(negedge clock);
        check("midreset sum_1p2",   sum_1p2,  '0);
        check("midreset sum_11p2",  sum_11p2, '0);
        check("midreset done_11p1", W'(done_11p1), '0);
        reset = 1'b1;
        repeat (80) @(negedge clock);
        check("no load after reset", W'(done_1p1), '0);

        // Load in the middle of a long scan restarts everything.
        set_one(1000, 100000);
        pulse_load();
        repeat (100) @(negedge clock);
        set_one(11, 22);
        run_all(1'b0);
        check_one("reload", 33, 33);

        // Random ranges clustered around repeated-block numbers, with some empty ranges and en pauses.
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < N11; i++) begin
                blk   = longint'($urandom_range(1, 9999));
                scale = 10;
                while (scale <= blk) scale *= 10;
                v = blk;
                for (int r = 1; r < int'($urandom_range(2, 3)); r++) v = v * scale + blk;
                off = longint'($urandom_range(0, 60));
                if (off > v) off = v;
                ra[i] = v - off;
                rb[i] = v + longint'($urandom_range(0, 60));
                if ($urandom_range(0, 9) == 0) begin
                    ra[i] = rb[i] + 1;
                end
                s11[i] = W'(ra[i]);
                e11[i] = W'(rb[i]);
            end
            s1[0] = W'(ra[0]);
            e1[0] = W'(rb[0]);
            run_all(1'b1);
            exp1 = 0; exp2 = 0; ec1 = 0; ec2 = 0;
            for (int i = 0; i < N11; i++) begin
                exp1 += model_sum(ra[i], rb[i], 1);
                exp2 += model_sum(ra[i], rb[i], 2);
                ec1  += model_cnt(ra[i], rb[i], 1);
                ec2  += model_cnt(ra[i], rb[i], 2);
            end
            check_done($sformatf("rand%0d", round));
            check($sformatf("rand%0d sum_11p1", round), sum_11p1, W'(exp1));
            check($sformatf("rand%0d sum_11p2", round), sum_11p2, W'(exp2));
            check($sformatf("rand%0d sum_1p1", round),  sum_1p1,  W'(model_sum(ra[0], rb[0], 1)));
            check($sformatf("rand%0d sum_1p2", round),  sum_1p2,  W'(model_sum(ra[0], rb[0], 2)));
`ifdef DAY2_INVALID_COUNT_EN
            check($sformatf("rand%0d cnt_11p1", round), cnt_11p1, W'(ec1));
            check($sformatf("rand%0d cnt_11p2", round), cnt_11p2, W'(ec2));
            check($sformatf("rand%0d cnt_1p1", round),  cnt_1p1,  W'(model_cnt(ra[0], rb[0], 1)));
            check($sformatf("rand%0d cnt_1p2", round),  cnt_1p2,  W'(model_cnt(ra[0], rb[0], 2)));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
